// File: rtl/display_receiver_pkg.sv
// Shared definitions for the display link: FSM encoding and default frame geometry/timeout.
// Also used by the display transmitter so both ends agree on WORDS and timeout defaults.
package display_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

  localparam int DEFAULT_WORDS          = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 8191;
  localparam int IDLE_CNT_W             = 13;

  function automatic logic nibble_invalid(input logic [3:0] nibble);
    return nibble > 4'd9;
  endfunction

endpackage

// File: rtl/display_receiver_if.sv
// Serial display link plus decoded frame outputs; master = transmitter/consumer side, slave = receiver.
interface display_receiver_if
  import display_receiver_pkg::*;
#(
  parameter int WORDS = DEFAULT_WORDS
);

  logic                 DATA_CLOCK_SIGNAL;
  logic                 ENABLE_SIGNAL;
  logic                 VALUE_SIGNAL;
  logic [4*WORDS-1:0]   VALUE_BCD;
  logic                 FRAME_VALID;
  logic                 FRAME_ERROR;
  logic                 DIGIT_ERROR;

  modport master (
    output DATA_CLOCK_SIGNAL, ENABLE_SIGNAL, VALUE_SIGNAL,
    input  VALUE_BCD, FRAME_VALID, FRAME_ERROR, DIGIT_ERROR
  );

  modport slave (
    input  DATA_CLOCK_SIGNAL, ENABLE_SIGNAL, VALUE_SIGNAL,
    output VALUE_BCD, FRAME_VALID, FRAME_ERROR, DIGIT_ERROR
  );

endinterface

// File: rtl/display_rx_sync.sv
// Two-flop synchronizer for one asynchronous bit; clears to 0 on reset.
module display_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_bit,
  output logic sync_bit
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_bit <= 1'b0;
    end else begin
      meta     <= async_bit;
      sync_bit <= meta;
    end
  end

endmodule

// File: rtl/display_receiver.sv
// Serial BCD display receiver: samples on falling DATA_CLOCK edges, frames by ENABLE, flags short/long/stalled frames.
// Optional nibble range check built only when DISPLAY_RX_BCD_CHECK_EN is defined.
module display_receiver
  import display_receiver_pkg::*;
#(
  parameter int WORDS          = DEFAULT_WORDS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               internal_clock,
  input  logic               rst,
  display_receiver_if.slave  bus
);

  localparam int NBITS = 4 * WORDS;
  localparam int BW    = $clog2(NBITS);
  localparam logic [BW-1:0]         LAST_BIT = BW'(NBITS - 1);
  localparam logic [IDLE_CNT_W-1:0] TMO      = IDLE_CNT_W'(TIMEOUT_CYCLES);

  logic dclk_s, en_s, val_s;
  logic dclk_d;
  logic fall;

  display_rx_sync u_sync_dclk (.clk(internal_clock), .rst(rst), .async_bit(bus.DATA_CLOCK_SIGNAL), .sync_bit(dclk_s));
  display_rx_sync u_sync_en   (.clk(internal_clock), .rst(rst), .async_bit(bus.ENABLE_SIGNAL),     .sync_bit(en_s));
  display_rx_sync u_sync_val  (.clk(internal_clock), .rst(rst), .async_bit(bus.VALUE_SIGNAL),      .sync_bit(val_s));

  assign fall = dclk_d & ~dclk_s;

  rx_state_t             state, state_nxt;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_pos;
  logic [IDLE_CNT_W-1:0] idle_cnt;
  logic [NBITS-1:0]      shreg;
  logic [NBITS-1:0]      value_bcd;
  logic                  frame_valid;
  logic                  frame_error;
  // drain: a frame just completed and ENABLE has not yet been seen low; ovr: overrun already reported
  logic                  drain, drain_nxt;
  logic                  ovr, ovr_nxt;
  logic                  capture, abort, load, ovr_err;

  // Nibbles arrive MSB first, so the low two bits of the position are the bit counter's complemented.
  assign bit_pos = bit_cnt ^ BW'(3);

  always_ff @(posedge internal_clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain;
    ovr_nxt   = ovr;
    capture   = 1'b0;
    abort     = 1'b0;
    load      = 1'b0;
    ovr_err   = 1'b0;
    case (state)
      IDLE: begin
        if (drain) begin
          if (!en_s) begin
            drain_nxt = 1'b0;
            ovr_nxt   = 1'b0;
          end else if (fall && !ovr) begin
            ovr_err = 1'b1;
            ovr_nxt = 1'b1;
          end
        end else if (fall && en_s) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          if (en_s) begin
            capture = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = DONE;
            end
          end else begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end
        end else if (idle_cnt == TMO) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        load      = 1'b1;
        drain_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge internal_clock or posedge rst) begin
    if (rst) begin
      dclk_d      <= 1'b0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      shreg       <= '0;
      value_bcd   <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      drain       <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      dclk_d      <= dclk_s;
      drain       <= drain_nxt;
      ovr         <= ovr_nxt;
      frame_valid <= load;
      frame_error <= abort | ovr_err;

      if (capture) begin
        shreg[bit_pos] <= val_s;
      end

      if (state_nxt != SHIFT) begin
        bit_cnt <= '0;
      end else if (capture) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state_nxt != SHIFT || fall) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (load) begin
        value_bcd <= shreg;
      end
    end
  end

  assign bus.VALUE_BCD   = value_bcd;
  assign bus.FRAME_VALID = frame_valid;
  assign bus.FRAME_ERROR = frame_error;

`ifdef DISPLAY_RX_BCD_CHECK_EN
  logic bad_digit;
  logic digit_error;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (nibble_invalid(shreg[4*i +: 4])) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge internal_clock or posedge rst) begin
    if (rst) begin
      digit_error <= 1'b0;
    end else if (load) begin
      digit_error <= bad_digit;
    end
  end

  assign bus.DIGIT_ERROR = digit_error;
`else
  assign bus.DIGIT_ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_display_receiver.sv
// Bench for display_receiver: serial transmitter model, frame scoreboard, scenario tasks.
module tb_display_receiver;

  logic clk;
  logic rst;

  display_receiver_if #(.WORDS(4)) bus ();

  display_receiver #(.WORDS(4), .TIMEOUT_CYCLES(8191)) dut (
    .internal_clock (clk),
    .rst            (rst),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DISPLAY_RX_BCD_CHECK_EN
  localparam logic EXP_BAD = 1'b1;
`else
  localparam logic EXP_BAD = 1'b0;
`endif

  int          tests;
  int          fails;
  int          valid_seen;
  int          err_seen;
  logic [15:0] exp_q[$];
  bit          lat_chk;
  time         last_fall;

  // Scoreboard: every FRAME_VALID pops one expected frame.
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.FRAME_ERROR === 1'b1) err_seen++;
    if (bus.FRAME_VALID === 1'b1) begin
      valid_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_frame got=%h expected no frame", bus.VALUE_BCD);
      end else begin
        e = exp_q.pop_front();
        if (bus.VALUE_BCD !== e) begin
          fails++;
          $display("FAIL sb_value got=%h expected=%h", bus.VALUE_BCD, e);
        end
      end
      tests++;
      if (bus.FRAME_ERROR !== 1'b0) begin
        fails++;
        $display("FAIL sb_exclusive frame_error=%b expected 0 with frame_valid", bus.FRAME_ERROR);
      end
      if (lat_chk) begin
        tests++;
        if (($time - last_fall) != 40) begin
          fails++;
          $display("FAIL sb_latency got=%0t expected=40 after last falling clock", $time - last_fall);
        end
      end
    end
  end

  function automatic logic ser_bit(input logic [15:0] v, input int k);
    if (k >= 16) return 1'b0;
    return v[(k / 4) * 4 + 3 - (k % 4)];
  endfunction

  task automatic send_frame(input logic [15:0] v, input int nbits, input int nen, input int half);
    for (int k = 0; k < nbits; k++) begin
      bus.ENABLE_SIGNAL     = (k < nen);
      bus.VALUE_SIGNAL      = ser_bit(v, k);
      bus.DATA_CLOCK_SIGNAL = 1'b1;
      repeat (half) @(negedge clk);
      bus.DATA_CLOCK_SIGNAL = 1'b0;
      last_fall = $time;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    bus.ENABLE_SIGNAL = 1'b0;
    bus.VALUE_SIGNAL  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_outputs(input string name, input logic [15:0] v, input logic de);
    tests++;
    if (bus.VALUE_BCD !== v) begin
      fails++;
      $display("FAIL %s_value got=%h expected=%h", name, bus.VALUE_BCD, v);
    end
    tests++;
    if (bus.DIGIT_ERROR !== de) begin
      fails++;
      $display("FAIL %s_digit_error got=%b expected=%b", name, bus.DIGIT_ERROR, de);
    end
  endtask

  task automatic check_counts(input string name, input int v0, input int e0, input int dv, input int de);
    tests++;
    if (valid_seen - v0 != dv) begin
      fails++;
      $display("FAIL %s_valid_pulses got=%0d expected=%0d", name, valid_seen - v0, dv);
    end
    tests++;
    if (err_seen - e0 != de) begin
      fails++;
      $display("FAIL %s_error_pulses got=%0d expected=%0d", name, err_seen - e0, de);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.DATA_CLOCK_SIGNAL = 1'b0;
    bus.ENABLE_SIGNAL     = 1'b0;
    bus.VALUE_SIGNAL      = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 16'h0000, 1'b0);
    tests++;
    if (bus.FRAME_VALID !== 1'b0 || bus.FRAME_ERROR !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses got=%b%b expected=00", bus.FRAME_VALID, bus.FRAME_ERROR);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0 = valid_seen, e0 = err_seen;
    lat_chk = 1'b1;
    exp_q.push_back(16'h1234);
    send_frame(16'h1234, 16, 16, 2001);
    end_frame();
    lat_chk = 1'b0;
    check_outputs("basic", 16'h1234, 1'b0);
    check_counts("basic", v0, e0, 1, 0);
  endtask

  task automatic test_short_frame();
    int v0 = valid_seen, e0 = err_seen;
    send_frame(16'hFFFF, 10, 9, 6);
    end_frame();
    check_outputs("short", 16'h1234, 1'b0);
    check_counts("short", v0, e0, 0, 1);
  endtask

  task automatic test_bad_digit();
    int v0 = valid_seen, e0 = err_seen;
    lat_chk = 1'b1;
    exp_q.push_back(16'h12A4);
    send_frame(16'h12A4, 16, 16, 6);
    end_frame();
    lat_chk = 1'b0;
    check_outputs("bad_digit", 16'h12A4, EXP_BAD);
    check_counts("bad_digit", v0, e0, 1, 0);
  endtask

  task automatic test_timeout();
    int v0 = valid_seen, e0 = err_seen;
    send_frame(16'hFFFF, 6, 6, 6);
    repeat (8100) @(negedge clk);
    check_counts("timeout_early", v0, e0, 0, 0);
    repeat (900) @(negedge clk);
    check_counts("timeout", v0, e0, 0, 1);
    end_frame();
    lat_chk = 1'b1;
    exp_q.push_back(16'h0987);
    send_frame(16'h0987, 16, 16, 6);
    end_frame();
    lat_chk = 1'b0;
    check_outputs("after_timeout", 16'h0987, 1'b0);
    check_counts("after_timeout", v0, e0, 1, 1);
  endtask

  task automatic test_long_frame();
    int v0 = valid_seen, e0 = err_seen;
    exp_q.push_back(16'h4321);
    send_frame(16'h4321, 21, 20, 6);
    end_frame();
    check_outputs("long", 16'h4321, 1'b0);
    check_counts("long", v0, e0, 1, 1);
  endtask

  task automatic test_reset_mid_frame();
    int v0 = valid_seen, e0 = err_seen;
    send_frame(16'h9999, 10, 10, 6);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("mid_reset", 16'h0000, 1'b0);
    bus.ENABLE_SIGNAL = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_outputs("mid_reset_after", 16'h0000, 1'b0);
    check_counts("mid_reset", v0, e0, 0, 0);
    lat_chk = 1'b1;
    exp_q.push_back(16'h5555);
    send_frame(16'h5555, 16, 16, 6);
    end_frame();
    lat_chk = 1'b0;
    check_outputs("after_reset", 16'h5555, 1'b0);
    check_counts("after_reset", v0, e0, 1, 0);
  endtask

  task automatic test_back_to_back();
    int v0 = valid_seen, e0 = err_seen;
    lat_chk = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h9876);
    send_frame(16'h0000, 16, 16, 4);
    bus.ENABLE_SIGNAL = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(16'h9876, 16, 16, 4);
    end_frame();
    lat_chk = 1'b0;
    check_outputs("b2b", 16'h9876, 1'b0);
    check_counts("b2b", v0, e0, 2, 0);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    valid_seen = 0;
    err_seen   = 0;
    lat_chk    = 1'b0;
    last_fall  = 0;
    rst        = 1'b1;
    test_reset();
    test_basic();
    test_short_frame();
    test_bad_digit();
    test_timeout();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got=%0d frames pending expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
